// File: rtl/mini_cpu_pkg.sv
// -----------------------------------------------------------------------------
// mini_cpu_pkg
//   Shared definitions for the mini CPU control path: opcode values, IR field
//   positions, instruction classes, sequencer state encoding and the
//   opcode -> class helper.
// -----------------------------------------------------------------------------
package mini_cpu_pkg;

  localparam int OPCODE_W = 5;
  localparam int FIELD_W  = 4;

  // IR field positions
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int RA_MSB  = 26;
  localparam int RA_LSB  = 23;
  localparam int RB_MSB  = 22;
  localparam int RB_LSB  = 19;
  localparam int RC_MSB  = 18;
  localparam int RC_LSB  = 15;

  // Opcodes
  localparam logic [OPCODE_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPCODE_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPCODE_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OPCODE_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OPCODE_W-1:0] OP_SHR  = 5'b00111;
  localparam logic [OPCODE_W-1:0] OP_SHL  = 5'b01000;
  localparam logic [OPCODE_W-1:0] OP_NOT  = 5'b01001;
  localparam logic [OPCODE_W-1:0] OP_NEG  = 5'b01010;
  localparam logic [OPCODE_W-1:0] OP_MUL  = 5'b01011;
  localparam logic [OPCODE_W-1:0] OP_DIV  = 5'b01100;
  localparam logic [OPCODE_W-1:0] OP_NOP  = 5'b11000;
  localparam logic [OPCODE_W-1:0] OP_HALT = 5'b11011;

  // Execute-sequence families
  typedef enum logic [2:0] {
    CLS_ALU3   = 3'd0,  // Rb -> Y, Y op Rc -> Z, Z -> Ra
    CLS_ALU2   = 3'd1,  // op Rb -> Z, Z -> Ra
    CLS_MULDIV = 3'd2,  // Rb -> Y, Y op Rc -> Z(hi:lo), lo -> LO, hi -> HI
    CLS_NOP    = 3'd3,  // also every undefined opcode
    CLS_HALT   = 3'd4
  } op_class_e;

  // Sequencer states (4-bit)
  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_T0     = 4'd1,
    ST_T1     = 4'd2,
    ST_T2     = 4'd3,
    ST_T3     = 4'd4,
    ST_T4     = 4'd5,
    ST_T5     = 4'd6,
    ST_T6     = 4'd7,
    ST_HALTED = 4'd8
  } state_e;

  function automatic op_class_e classify(input logic [OPCODE_W-1:0] opcode);
    op_class_e cls;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL: cls = CLS_ALU3;
      OP_NOT, OP_NEG:                                cls = CLS_ALU2;
      OP_MUL, OP_DIV:                                cls = CLS_MULDIV;
      OP_HALT:                                       cls = CLS_HALT;
      default:                                       cls = CLS_NOP;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/reg_field_decoder.sv
// -----------------------------------------------------------------------------
// reg_field_decoder
//   Decodes a 4-bit register field into a one-hot register select.
//   Ports:
//     field   in  4     register number
//     en      in  1     0 forces the output to all zeros
//     onehot  out NREG  bit n set when en=1 and field=n
// -----------------------------------------------------------------------------
module reg_field_decoder #(
  parameter int NREG = 16
) (
  input  logic [3:0]      field,
  input  logic            en,
  output logic [NREG-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[field] = 1'b1;
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// -----------------------------------------------------------------------------
// ctrl_sequencer
//   Hardwired control unit for the mini CPU. Runs fetch (T0-T2) and then an
//   opcode-specific execute sequence, one micro-step per Clock, driving the
//   data_path strobes. Outputs are Moore-decoded from the state register plus
//   the IR fields, so they are stable for the whole cycle.
//
//   Optional feature: define CTRL_STEP_EN to add a 'step' input. Leaving IDLE
//   then also needs a one-cycle step pulse, and every instruction returns to
//   IDLE when it finishes, giving single-instruction stepping.
//
//   Ports:
//     Clock        in   1     rising-edge clock
//     clear        in   1     asynchronous active-low reset
//     run          in   1     1 = keep executing, 0 = stop at next boundary
//     mem_ready    in   1     memory read complete (looked at in T1 only)
//     step         in   1     single-step pulse (CTRL_STEP_EN builds only)
//     ir           in   32    opcode [31:27], Ra [26:23], Rb [22:19], Rc [18:15]
//     PCout..IRin  out  1     fetch strobes
//     Yin..HIin    out  1     execute strobes
//     Rin          out  NREG  one-hot register write enable
//     Rout         out  NREG  one-hot register bus drive
//     op           out  OPW   ALU opcode, 0 outside the steps that use it
//     instr_done   out  1     high in the last step of every instruction
//     halted       out  1     sticky after HALT retires, cleared by clear
// -----------------------------------------------------------------------------
module ctrl_sequencer
  import mini_cpu_pkg::*;
#(
  parameter int OPW  = 5,
  parameter int NREG = 16
) (
  input  logic            Clock,
  input  logic            clear,
  input  logic            run,
  input  logic            mem_ready,
`ifdef CTRL_STEP_EN
  input  logic            step,
`endif
  input  logic [31:0]     ir,
  output logic            PCout,
  output logic            InPC,
  output logic            MARin,
  output logic            PCin,
  output logic            Read,
  output logic            MDRin,
  output logic            MDRout,
  output logic            IRin,
  output logic            Yin,
  output logic            Zlowin,
  output logic            ZHighin,
  output logic            Zlowout,
  output logic            Zhighout,
  output logic            LOin,
  output logic            HIin,
  output logic [NREG-1:0] Rin,
  output logic [NREG-1:0] Rout,
  output logic [OPW-1:0]  op,
  output logic            instr_done,
  output logic            halted
);

  state_e                state;
  op_class_e             op_class;
  logic [OPCODE_W-1:0]   opcode;
  logic                  rin_en;
  logic                  rout_en;
  logic                  rout_sel_rc;   // 1: Rout addresses Rc, 0: Rb
  logic                  op_en;
  logic                  start_ok;      // IDLE may move to T0
  state_e                boundary_next; // where a finished instruction goes
  logic [FIELD_W-1:0]    rout_field;
  logic                  unused_ir;

  assign opcode    = ir[OPC_MSB:OPC_LSB];
  assign op_class  = classify(opcode);
  assign unused_ir = ^ir[RC_LSB-1:0];

`ifdef CTRL_STEP_EN
  assign start_ok      = run & step;
  assign boundary_next = ST_IDLE;
`else
  assign start_ok      = run;
  assign boundary_next = run ? ST_T0 : ST_IDLE;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      state  <= ST_IDLE;
      halted <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (start_ok) state <= ST_T0;
        ST_T0:   state <= ST_T1;
        ST_T1:   if (mem_ready) state <= ST_T2;
        ST_T2:   state <= ST_T3;
        ST_T3: begin
          case (op_class)
            CLS_ALU3, CLS_ALU2, CLS_MULDIV: state <= ST_T4;
            CLS_HALT: begin
              state  <= ST_HALTED;
              halted <= 1'b1;
            end
            default: state <= boundary_next;
          endcase
        end
        ST_T4:     state <= (op_class == CLS_ALU2) ? boundary_next : ST_T5;
        ST_T5:     state <= (op_class == CLS_MULDIV) ? ST_T6 : boundary_next;
        ST_T6:     state <= boundary_next;
        ST_HALTED: state <= ST_HALTED;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: every output of this block gets a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    PCout       = 1'b0;
    InPC        = 1'b0;
    MARin       = 1'b0;
    PCin        = 1'b0;
    Read        = 1'b0;
    MDRin       = 1'b0;
    MDRout      = 1'b0;
    IRin        = 1'b0;
    Yin         = 1'b0;
    Zlowin      = 1'b0;
    ZHighin     = 1'b0;
    Zlowout     = 1'b0;
    Zhighout    = 1'b0;
    LOin        = 1'b0;
    HIin        = 1'b0;
    rin_en      = 1'b0;
    rout_en     = 1'b0;
    rout_sel_rc = 1'b0;
    op_en       = 1'b0;
    instr_done  = 1'b0;

    case (state)
      ST_T0: begin
        PCout  = 1'b1;
        MARin  = 1'b1;
        InPC   = 1'b1;
        Zlowin = 1'b1;
      end
      ST_T1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      ST_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      ST_T3: begin
        case (op_class)
          CLS_ALU3, CLS_MULDIV: begin
            rout_en = 1'b1;
            Yin     = 1'b1;
          end
          CLS_ALU2: begin
            rout_en = 1'b1;
            op_en   = 1'b1;
            Zlowin  = 1'b1;
          end
          default: instr_done = 1'b1;  // NOP, HALT and undefined opcodes
        endcase
      end
      ST_T4: begin
        case (op_class)
          CLS_ALU3, CLS_MULDIV: begin
            rout_en     = 1'b1;
            rout_sel_rc = 1'b1;
            op_en       = 1'b1;
            Zlowin      = 1'b1;
            ZHighin     = (op_class == CLS_MULDIV);
          end
          CLS_ALU2: begin
            Zlowout    = 1'b1;
            rin_en     = 1'b1;
            instr_done = 1'b1;
          end
          default: ;
        endcase
      end
      ST_T5: begin
        case (op_class)
          CLS_ALU3: begin
            Zlowout    = 1'b1;
            rin_en     = 1'b1;
            instr_done = 1'b1;
          end
          CLS_MULDIV: begin
            Zlowout = 1'b1;
            LOin    = 1'b1;
          end
          default: ;
        endcase
      end
      ST_T6: begin
        if (op_class == CLS_MULDIV) begin
          Zhighout   = 1'b1;
          HIin       = 1'b1;
          instr_done = 1'b1;
        end
      end
      default: ;  // IDLE and HALTED drive nothing
    endcase
  end

  assign op         = op_en ? OPW'(opcode) : '0;
  assign rout_field = rout_sel_rc ? ir[RC_MSB:RC_LSB] : ir[RB_MSB:RB_LSB];

  reg_field_decoder #(.NREG(NREG)) u_rin_dec (
    .field  (ir[RA_MSB:RA_LSB]),
    .en     (rin_en),
    .onehot (Rin)
  );

  reg_field_decoder #(.NREG(NREG)) u_rout_dec (
    .field  (rout_field),
    .en     (rout_en),
    .onehot (Rout)
  );

endmodule

// File: tb/tb_ctrl_sequencer.sv
// -----------------------------------------------------------------------------
// tb_ctrl_sequencer
//   Self-checking bench for ctrl_sequencer. Each instruction is expanded into
//   its list of expected micro-steps (fetch, stall repeats, execute) and the
//   DUT outputs are compared against that list one cycle at a time.
// -----------------------------------------------------------------------------
module tb_ctrl_sequencer;

`ifdef CTRL_STEP_EN
  localparam bit STEP_MODE = 1'b1;
`else
  localparam bit STEP_MODE = 1'b0;
`endif

  // strobe masks, bit order of snap_t.strb
  localparam logic [14:0] B_PCOUT    = 15'd1 << 0;
  localparam logic [14:0] B_INPC     = 15'd1 << 1;
  localparam logic [14:0] B_MARIN    = 15'd1 << 2;
  localparam logic [14:0] B_PCIN     = 15'd1 << 3;
  localparam logic [14:0] B_READ     = 15'd1 << 4;
  localparam logic [14:0] B_MDRIN    = 15'd1 << 5;
  localparam logic [14:0] B_MDROUT   = 15'd1 << 6;
  localparam logic [14:0] B_IRIN     = 15'd1 << 7;
  localparam logic [14:0] B_YIN      = 15'd1 << 8;
  localparam logic [14:0] B_ZLOWIN   = 15'd1 << 9;
  localparam logic [14:0] B_ZHIGHIN  = 15'd1 << 10;
  localparam logic [14:0] B_ZLOWOUT  = 15'd1 << 11;
  localparam logic [14:0] B_ZHIGHOUT = 15'd1 << 12;
  localparam logic [14:0] B_LOIN     = 15'd1 << 13;
  localparam logic [14:0] B_HIIN     = 15'd1 << 14;

  typedef struct packed {
    logic [14:0] strb;
    logic [15:0] rin;
    logic [15:0] rout;
    logic [4:0]  op;
    logic        done;
    logic        halted;
  } snap_t;

  logic        Clock = 1'b0;
  logic        clear, run, mem_ready;
`ifdef CTRL_STEP_EN
  logic        step;
`endif
  logic [31:0] ir;
  logic PCout, InPC, MARin, PCin, Read, MDRin, MDRout, IRin;
  logic Yin, Zlowin, ZHighin, Zlowout, Zhighout, LOin, HIin;
  logic [15:0] Rin, Rout;
  logic [4:0]  op;
  logic        instr_done, halted;

  snap_t obs;
  snap_t exp_q[$];
  int    pass_cnt  = 0;
  int    total_cnt = 0;

  always #5 Clock = ~Clock;

  ctrl_sequencer #(.OPW(5), .NREG(16)) dut (
    .Clock      (Clock),
    .clear      (clear),
    .run        (run),
    .mem_ready  (mem_ready),
`ifdef CTRL_STEP_EN
    .step       (step),
`endif
    .ir         (ir),
    .PCout      (PCout),
    .InPC       (InPC),
    .MARin      (MARin),
    .PCin       (PCin),
    .Read       (Read),
    .MDRin      (MDRin),
    .MDRout     (MDRout),
    .IRin       (IRin),
    .Yin        (Yin),
    .Zlowin     (Zlowin),
    .ZHighin    (ZHighin),
    .Zlowout    (Zlowout),
    .Zhighout   (Zhighout),
    .LOin       (LOin),
    .HIin       (HIin),
    .Rin        (Rin),
    .Rout       (Rout),
    .op         (op),
    .instr_done (instr_done),
    .halted     (halted)
  );

  always_comb begin
    obs.strb   = {HIin, LOin, Zhighout, Zlowout, ZHighin, Zlowin, Yin,
                  IRin, MDRout, MDRin, Read, PCin, MARin, InPC, PCout};
    obs.rin    = Rin;
    obs.rout   = Rout;
    obs.op     = op;
    obs.done   = instr_done;
    obs.halted = halted;
  end

  function automatic snap_t mk(input logic [14:0] s, input logic [15:0] rin,
                               input logic [15:0] rout, input logic [4:0] opv,
                               input logic done, input logic h);
    snap_t r;
    r.strb = s; r.rin = rin; r.rout = rout; r.op = opv; r.done = done; r.halted = h;
    return r;
  endfunction

  function automatic logic [31:0] enc(input logic [4:0] opc, input int ra,
                                      input int rb, input int rc);
    return {opc, 4'(ra), 4'(rb), 4'(rc), 15'h0};
  endfunction

  task automatic check(input string tag, input snap_t o, input snap_t e);
    total_cnt++;
    assert (o === e) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s: observed strb=%h rin=%h rout=%h op=%h done=%b halted=%b, expected strb=%h rin=%h rout=%h op=%h done=%b halted=%b",
             tag, o.strb, o.rin, o.rout, o.op, o.done, o.halted,
             e.strb, e.rin, e.rout, e.op, e.done, e.halted);
    end
  endtask

  // Expected micro-step list for one instruction with 'stalls' wait cycles in T1.
  task automatic build_steps(input logic [31:0] iv, input int stalls);
    logic [4:0]  opc;
    logic [15:0] a, b, c;
    opc = iv[31:27];
    a   = 16'd1 << iv[26:23];
    b   = 16'd1 << iv[22:19];
    c   = 16'd1 << iv[18:15];
    exp_q.delete();
    exp_q.push_back(mk(B_PCOUT | B_MARIN | B_INPC | B_ZLOWIN, 0, 0, 0, 0, 0));
    for (int k = 0; k <= stalls; k++)
      exp_q.push_back(mk(B_ZLOWOUT | B_PCIN | B_READ | B_MDRIN, 0, 0, 0, 0, 0));
    exp_q.push_back(mk(B_MDROUT | B_IRIN, 0, 0, 0, 0, 0));
    if (opc inside {5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8}) begin
      exp_q.push_back(mk(B_YIN, 0, b, 0, 0, 0));
      exp_q.push_back(mk(B_ZLOWIN, 0, c, opc, 0, 0));
      exp_q.push_back(mk(B_ZLOWOUT, a, 0, 0, 1, 0));
    end else if (opc inside {5'd9, 5'd10}) begin
      exp_q.push_back(mk(B_ZLOWIN, 0, b, opc, 0, 0));
      exp_q.push_back(mk(B_ZLOWOUT, a, 0, 0, 1, 0));
    end else if (opc inside {5'd11, 5'd12}) begin
      exp_q.push_back(mk(B_YIN, 0, b, 0, 0, 0));
      exp_q.push_back(mk(B_ZLOWIN | B_ZHIGHIN, 0, c, opc, 0, 0));
      exp_q.push_back(mk(B_ZLOWOUT | B_LOIN, 0, 0, 0, 0, 0));
      exp_q.push_back(mk(B_ZHIGHOUT | B_HIIN, 0, 0, 0, 1, 0));
    end else begin
      exp_q.push_back(mk(15'd0, 0, 0, 0, 1, 0));
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Entered at a sample point with the DUT in T0. Checks 'limit' steps
  // (0 = all); run follows run_final on the last step, random elsewhere.
  task automatic run_instr(input string tag, input logic [31:0] iv,
                           input int stalls, input bit run_final, input int limit);
    int n;
    ir = iv;
    build_steps(iv, stalls);
    n = (limit > 0) ? limit : exp_q.size();
    for (int i = 0; i < n; i++) begin
      if (i >= 1 && i <= stalls)  mem_ready = 1'b0;
      else if (i == stalls + 1)   mem_ready = 1'b1;
      else                        mem_ready = 1'($urandom);
      run = (i == exp_q.size() - 1) ? run_final : 1'($urandom);
      check($sformatf("%s_s%0d", tag, i), obs, exp_q[i]);
      tick();
    end
  endtask

  // From IDLE at a sample point: request start, confirm IDLE holds, enter T0.
  task automatic start();
    run = 1'b1;
`ifdef CTRL_STEP_EN
    step = 1'b0;
    check("wait_step", obs, '0);
    tick();
    step = 1'b1;
`endif
    check("idle_start", obs, '0);
    tick();
`ifdef CTRL_STEP_EN
    step = 1'b0;
`endif
  endtask

  // After an instruction: continue straight into T0, or via IDLE.
  task automatic after_instr(input bit run_final);
    if (!run_final || STEP_MODE) begin
      run = 1'b0;
      check("idle_boundary", obs, '0);
      tick();
      start();
    end
  endtask

  initial begin
    logic [31:0] iv;
    logic [4:0]  opc;
    bit          rf;
    int          st;

    clear = 1'b0; run = 1'b0; mem_ready = 1'b0; ir = 32'h0;
`ifdef CTRL_STEP_EN
    step = 1'b0;
`endif
    tick(); tick();
    check("reset_state", obs, '0);
    clear = 1'b1;
    tick();
    check("idle_run0", obs, '0);
    start();

    // ADD R3,R1,R2 then NOT R6,R7 back to back
    run_instr("add", enc(5'b00011, 3, 1, 2), 0, 1'b1, 0);
    after_instr(1'b1);
    run_instr("not", enc(5'b01001, 6, 7, 0), 0, 1'b0, 0);
    after_instr(1'b0);

    // three wait cycles in T1
    run_instr("add_stall", enc(5'b00011, 15, 0, 9), 3, 1'b1, 0);
    after_instr(1'b1);

    // randomized mix (HALT excluded)
    for (int n = 0; n < 40; n++) begin
      opc = 5'($urandom_range(0, 31));
      if (opc == 5'b11011) opc = 5'b11000;
      iv  = {opc, 27'($urandom)};
      st  = $urandom_range(0, 3);
      rf  = 1'($urandom);
      run_instr($sformatf("rnd%0d", n), iv, st, rf, 0);
      after_instr(rf);
    end

    // clear during T4 of ADD aborts at once
    run_instr("add_abort", enc(5'b00011, 3, 1, 2), 0, 1'b1, 4);
    check("abort_t4", obs, exp_q[4]);
    clear = 1'b0;
    #2;
    check("reset_mid_t4", obs, '0);
    tick();
    clear = 1'b1;
    run = 1'b0;
    check("idle_after_abort", obs, '0);
    tick();
    start();

    // MUL R4,R5 then HALT
    run_instr("mul", enc(5'b01011, 0, 4, 5), 1, 1'b1, 0);
    after_instr(1'b1);
    run_instr("halt", enc(5'b11011, 0, 0, 0), 0, 1'b1, 0);
    for (int k = 0; k < 6; k++) begin
      run = 1'($urandom);
      mem_ready = 1'($urandom);
`ifdef CTRL_STEP_EN
      step = 1'($urandom);
`endif
      check($sformatf("halted%0d", k), obs, mk(15'd0, 0, 0, 0, 0, 1));
      tick();
    end
    clear = 1'b0;
    #2;
    check("clear_halted", obs, '0);
    tick();
    clear = 1'b1;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
